// File: rtl/t02_wb_pkg.sv
// Shared types and constants for the core-to-Wishbone master bridge.
// Imported by the bridge top; keeps state encoding and bus constants in one place.
package t02_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } wb_state_t;

    localparam logic [3:0]  SEL_WORD         = 4'hF;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBAD0_BAD0;

    // The bus only carries whole words, so the byte offset is dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/t02_wb_timeout.sv
// Watchdog counter for one bus cycle: cleared on cycle start, counts while
// enabled, and flags the last permitted wait cycle.
module t02_wb_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int              CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = en && (count == LAST);

endmodule

// File: rtl/t02_wb_master_bridge.sv
// Turns one held core RAM request into a single classic Wishbone master cycle,
// holding the core busy until ack or watchdog timeout, then one DONE cycle.
module t02_wb_master_bridge
    import t02_wb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    input  logic        Ren,
    input  logic        Wen,
    output logic [31:0] ramload,
    output logic        busy_o,
    output logic        bus_err,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    wb_state_t state, state_next;

    logic req;
    logic start;
    logic in_bus;
    logic expired;
    logic finish_ack;
    logic finish_to;

    assign req        = Ren | Wen;
    assign start      = (state == IDLE) && req;
    assign in_bus     = (state == BUS);
    assign finish_ack = in_bus && wb_ack_i;
    assign finish_to  = in_bus && !wb_ack_i && expired;

    t02_wb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .nrst    (nrst),
        .clr     (start),
        .en      (in_bus),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        busy_o     = 1'b0;
        unique case (state)
            IDLE: begin
                // Combinational so the core stalls in the very cycle it asks.
                busy_o = req;
                if (req) begin
                    state_next = BUS;
                end
            end
            BUS: begin
                busy_o = 1'b1;
                if (wb_ack_i || expired) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ramload  <= '0;
            bus_err  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
            wb_we_o  <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
        end else begin
            bus_err <= finish_to;
            if (start) begin
                wb_adr_o <= word_align(ramaddr);
                wb_dat_o <= ramstore;
                wb_we_o  <= Wen;
                wb_sel_o <= SEL_WORD;
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
            end else if (finish_ack || finish_to) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                wb_we_o  <= 1'b0;
                // wb_we_o still reflects the cycle in flight at this edge.
                if (!wb_we_o) begin
                    ramload <= finish_ack ? wb_dat_i : ERR_DATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_t02_wb_master_bridge.sv
// Bench for the Wishbone master bridge: directed scenarios plus random
// transactions scored against a transaction-level model of the bridge.
module tb_t02_wb_master_bridge;

    localparam int          TO   = 4;
    localparam logic [31:0] ERRD = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic        Ren;
    logic        Wen;
    logic [31:0] ramload;
    logic        busy_o;
    logic        bus_err;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] model_load;

    always #5 clk = ~clk;

    t02_wb_master_bridge #(
        .TIMEOUT_CYCLES(TO),
        .ERR_DATA      (ERRD)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .Ren      (Ren),
        .Wen      (Wen),
        .ramload  (ramload),
        .busy_o   (busy_o),
        .bus_err  (bus_err),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i)
    );

    // One core transaction. ack_at is the 0-based BUS cycle on which the slave
    // acks (negative = never). Starts and ends 1 time unit after a rising edge.
    task automatic run_txn(input string name, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_at, input logic [31:0] rdata);
        int          bus_cycles  = 0;
        int          busy_cycles = 0;
        int          err_cycles  = 0;
        bit          done        = 1'b0;
        bit          exp_to;
        int          exp_bus;
        logic [31:0] seen_adr = 'x;
        logic [31:0] seen_dat = 'x;
        logic [3:0]  seen_sel = 'x;
        logic        seen_we  = 1'bx;

        exp_to  = (ack_at < 0) || (ack_at >= TO);
        exp_bus = exp_to ? TO : ack_at + 1;
        if (rd && !wr) model_load = exp_to ? ERRD : rdata;

        Ren = rd; Wen = wr; ramaddr = addr; ramstore = wdata;
        for (int i = 0; i < 64 && !done; i++) begin
            if (wb_cyc_o) begin
                if (bus_cycles == 0) begin
                    seen_adr = wb_adr_o; seen_dat = wb_dat_o;
                    seen_sel = wb_sel_o; seen_we  = wb_we_o;
                end
                wb_ack_i = (bus_cycles == ack_at);
                wb_dat_i = wb_ack_i ? rdata : $urandom();
                bus_cycles++;
            end else begin
                wb_ack_i = 1'b0;
                wb_dat_i = $urandom();
            end
            @(negedge clk);
            if (bus_err) err_cycles++;
            if (busy_o) busy_cycles++;
            else done = 1'b1;
            if (!done) begin
                @(posedge clk); #1;
            end
        end

        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: busy_o never dropped within 64 cycles", name);
        end
        vectors++;
        if (bus_cycles !== exp_bus) begin
            miscompares++;
            $display("FAIL %s cyc_cycles: got %0d expected %0d", name, bus_cycles, exp_bus);
        end
        vectors++;
        if (busy_cycles !== exp_bus + 1) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cycles, exp_bus + 1);
        end
        vectors++;
        if (err_cycles !== (exp_to ? 1 : 0)) begin
            miscompares++;
            $display("FAIL %s bus_err_cycles: got %0d expected %0d", name, err_cycles, exp_to ? 1 : 0);
        end
        vectors++;
        if (ramload !== model_load) begin
            miscompares++;
            $display("FAIL %s ramload: got %h expected %h", name, ramload, model_load);
        end
        vectors++;
        if (seen_adr !== {addr[31:2], 2'b00}) begin
            miscompares++;
            $display("FAIL %s wb_adr_o: got %h expected %h", name, seen_adr, {addr[31:2], 2'b00});
        end
        vectors++;
        if (seen_we !== wr) begin
            miscompares++;
            $display("FAIL %s wb_we_o: got %b expected %b", name, seen_we, wr);
        end
        vectors++;
        if (seen_sel !== 4'hF) begin
            miscompares++;
            $display("FAIL %s wb_sel_o: got %h expected f", name, seen_sel);
        end
        vectors++;
        if (seen_dat !== wdata) begin
            miscompares++;
            $display("FAIL %s wb_dat_o: got %h expected %h", name, seen_dat, wdata);
        end

        Ren = 1'b0; Wen = 1'b0; wb_ack_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if ({busy_o, wb_cyc_o, wb_stb_o, bus_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL %s idle_after: busy/cyc/stb/err=%b expected 0000", name,
                     {busy_o, wb_cyc_o, wb_stb_o, bus_err});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0; Ren = 1'b0; Wen = 1'b0; ramaddr = '0; ramstore = '0;
        wb_ack_i = 1'b0; wb_dat_i = '0; model_load = '0;
        #12;
        vectors++;
        if ({ramload, busy_o, bus_err, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: ramload=%h busy=%b err=%b adr=%h dat=%h sel=%h we=%b cyc=%b stb=%b expected all 0",
                     ramload, busy_o, bus_err, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o);
        end
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({busy_o, wb_cyc_o} !== 2'b00) begin
                miscompares++;
                $display("FAIL reset_idle: busy/cyc=%b expected 00", {busy_o, wb_cyc_o});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_wait_read();
        run_txn("zero_wait_read", 1'b1, 1'b0, 32'h0000_1006, 32'h5555_AAAA, 0, 32'hCAFE_F00D);
    endtask

    task automatic test_write_wait_states();
        run_txn("write_3_wait", 1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 3, 32'hDEAD_BEEF);
    endtask

    task automatic test_timeout();
        run_txn("read_timeout", 1'b1, 1'b0, 32'h0000_4443, 32'h0, -1, 32'h0);
    endtask

    task automatic test_simultaneous();
        run_txn("ren_wen_ack_at_timeout", 1'b1, 1'b1, 32'h0000_0104, 32'hA5A5_0F0F, TO - 1, 32'h7777_7777);
    endtask

    task automatic test_ack_ignored();
        for (int i = 0; i < 3; i++) begin
            wb_ack_i = 1'b1;
            wb_dat_i = $urandom();
            @(negedge clk);
            vectors++;
            if ({busy_o, wb_cyc_o, bus_err} !== 3'b000 || ramload !== model_load) begin
                miscompares++;
                $display("FAIL ack_ignored: busy/cyc/err=%b ramload=%h expected 000 and %h",
                         {busy_o, wb_cyc_o, bus_err}, ramload, model_load);
            end
            @(posedge clk); #1;
        end
        wb_ack_i = 1'b0;
    endtask

    // A write held through DONE must be re-issued as a second bus cycle.
    task automatic test_back_to_back();
        int cyc_cycles = 0;
        int done_cycles = 0;
        Wen = 1'b1; Ren = 1'b0; ramaddr = 32'h0000_0800; ramstore = 32'h0BAD_F00D;
        for (int i = 0; i < 6; i++) begin
            wb_ack_i = wb_cyc_o;
            @(negedge clk);
            if (wb_cyc_o) cyc_cycles++;
            if (!busy_o) done_cycles++;
            @(posedge clk); #1;
        end
        Wen = 1'b0; wb_ack_i = 1'b0;
        vectors++;
        if (cyc_cycles !== 2 || done_cycles !== 2) begin
            miscompares++;
            $display("FAIL back_to_back: cyc_cycles=%0d done_cycles=%0d expected 2 and 2", cyc_cycles, done_cycles);
        end
        vectors++;
        if (ramload !== model_load) begin
            miscompares++;
            $display("FAIL back_to_back ramload: got %h expected %h", ramload, model_load);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        Ren = 1'b1; Wen = 1'b0; ramaddr = 32'h0000_2000; wb_ack_i = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        vectors++;
        if ({busy_o, wb_cyc_o} !== 2'b11) begin
            miscompares++;
            $display("FAIL mid_reset_pre: busy/cyc=%b expected 11", {busy_o, wb_cyc_o});
        end
        nrst = 1'b0; Ren = 1'b0;
        #1;
        model_load = '0;
        vectors++;
        if ({busy_o, wb_cyc_o, wb_stb_o} !== 3'b000 || ramload !== model_load) begin
            miscompares++;
            $display("FAIL mid_reset_drop: busy/cyc/stb=%b ramload=%h expected 000 and 0",
                     {busy_o, wb_cyc_o, wb_stb_o}, ramload);
        end
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
        run_txn("read_after_reset", 1'b1, 1'b0, 32'h0000_3008, 32'h0, 1, 32'h1357_9BDF);
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            int          kind;
            int          ack_at;
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] r;
            kind   = $urandom_range(0, 2);
            ack_at = $urandom_range(0, 5);
            if (ack_at == 5) ack_at = -1;
            a = $urandom(); d = $urandom(); r = $urandom();
            run_txn($sformatf("random_%0d", n), kind != 1, kind != 0, a, d, ack_at, r);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_write_wait_states();
        test_timeout();
        test_simultaneous();
        test_ack_ignored();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/t02_wb_master_bridge.md
Name: t02_wb_master_bridge

Overview:
- Sits directly downstream of the CPU core's RAM request port (ramaddr/ramstore/Ren/Wen/ramload/busy_o).
- Converts each single-word core request into one classic Wishbone B4 master cycle (cyc/stb/we/ack) toward the shared SRAM/peripheral bus.
- Drives busy_o back to the core until the bus transaction completes.
- A watchdog terminates hung cycles so the core never stalls forever.

Parameters:
- TIMEOUT_CYCLES, 255: max BUS-state cycles waiting for ack_i before forced termination; must be >= 1.
- ERR_DATA, 32'hBAD0_BAD0: value returned on ramload when a read times out.

Ports:
- clk  input  1  system clock; all state on rising edge.
- nrst  input  1  asynchronous active-low reset.
- ramaddr  input  32  core byte address.
- ramstore  input  32  core write data.
- Ren  input  1  core read request; held until busy_o low.
- Wen  input  1  core write request; held until busy_o low.
- ramload  output  32  read data to core.
- busy_o  output  1  core must hold request while high.
- bus_err  output  1  one-cycle pulse on timeout.
- wb_adr_o  output  32  word-aligned bus address.
- wb_dat_o  output  32  bus write data.
- wb_sel_o  output  4  byte lanes.
- wb_we_o  output  1  write strobe.
- wb_cyc_o  output  1  cycle valid.
- wb_stb_o  output  1  strobe.
- wb_dat_i  input  32  bus read data.
- wb_ack_i  input  1  slave acknowledge.

Behaviour:
- Reset (async, nrst low): state IDLE; ramload=0, busy_o=0, bus_err=0, all wb_* outputs 0, timeout counter 0. Reset asserted mid-transaction drops cyc/stb immediately; no completion is reported.
- States: IDLE, BUS, DONE.
- IDLE:
  - busy_o = Ren|Wen, combinational, so the core sees busy in the same cycle it raises a request.
  - On a clock edge with Ren|Wen: latch wb_adr_o={ramaddr[31:2],2'b00}, wb_dat_o=ramstore, wb_we_o=Wen, wb_sel_o=4'hF. Assert cyc/stb (registered). Clear counter. Go to BUS.
  - Ren and Wen both high: treat as write (Wen priority); Ren ignored.
- BUS:
  - busy_o=1; cyc/stb held high; counter increments each cycle.
  - wb_ack_i high: deassert cyc/stb/we on the next edge. If a read, capture wb_dat_i into ramload. Go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 with no ack: deassert cyc/stb. If a read, ramload=ERR_DATA. bus_err=1 for exactly one cycle (the DONE cycle). Go to DONE.
  - Ack and timeout on the same cycle: ack wins; no bus_err.
- DONE:
  - busy_o=0 for exactly one cycle; the core samples ramload at this edge. Next state is IDLE unconditionally.
  - A request still held in DONE is not sampled. It is re-evaluated in IDLE, so back-to-back identical requests issue two bus cycles.
- ramload holds its last value across writes and idle cycles; it is updated only by a completed read or a read timeout.
- Latency: request seen in IDLE at edge N; cyc/stb high from N+1. With ack in the first BUS cycle, DONE (busy_o low) in cycle N+2. Each extra wait state adds 1.
- ack_i outside BUS is ignored.
- Counter width is $clog2(TIMEOUT_CYCLES+1); no wrap is possible because it clears on entry to BUS.

Decomposition:
- Shared package t02_wb_pkg:
  - typedef enum logic [1:0] {IDLE, BUS, DONE} wb_state_t
  - localparam SEL_WORD=4'hF
  - default ERR_DATA constant
- One sub-module, t02_wb_timeout: counter with clear/enable inputs and an expired output, parameterized by TIMEOUT_CYCLES.

Test Plan:
- Reset/idle: hold nrst low, Ren=Wen=0 -> all outputs 0; after release busy_o stays 0 and cyc stays 0.
- Zero-wait read: Ren=1, ramaddr=32'h0000_1006; slave acks first BUS cycle with dat_i=32'hCAFE_F00D -> wb_adr_o=32'h0000_1004, we=0, sel=4'hF, cyc high exactly 1 cycle, busy_o low in cycle N+2, ramload=32'hCAFE_F00D.
- Write with 3 wait states: Wen=1, addr 32'h20, ramstore=32'h1234_5678, ack on 4th BUS cycle -> we=1, dat_o=32'h1234_5678, busy_o high 5 cycles then low 1, ramload unchanged.
- Timeout: TIMEOUT_CYCLES=4, Ren=1, never ack -> cyc high 4 cycles, ramload=32'hBAD0_BAD0, bus_err single-cycle pulse, back to IDLE.
- Simultaneous Ren+Wen -> we=1 write cycle; ack on the timeout cycle -> no bus_err.
- Mid-cycle reset: nrst low during BUS -> cyc/stb/busy_o drop asynchronously; after release a new read completes normally.
